// File: rtl/i2c_target.sv
// i2c_target: I2C bus target (slave) with a fixed 7-bit address.
//
// Ports:
//   clk       system clock, at least 8x the scl rate
//   reset     asynchronous, active-high
//   scl       bus clock from the controller
//   sda       bus data; open-drain (driven 0 or left 1'bz, never driven 1)
//   tx_byte   byte returned to the controller on reads
//   rx_byte   last byte written by the controller
//   rx_valid  one-clk pulse when rx_byte updates
//   tx_load   one-clk pulse when tx_byte is captured
//   busy      high from an address match to STOP or NACK
//   state     current FSM state, for debug
//
// Bus handshake: there is no valid/ready pair here. The controller owns the
// bus timing. Data is sampled on scl rising edges. The target changes its sda
// drive only after an scl falling edge, or on START, STOP or reset. rx_valid
// and tx_load are single-cycle strobes that the host cannot stall.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2   // must be >= 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ACK_ADDR = 4'd2,
    ST_RX_BYTE  = 4'd3,
    ST_ACK_RX   = 4'd4,
    ST_TX_BYTE  = 4'd5,
    ST_WAIT_ACK = 4'd6,
    ST_IGNORE   = 4'd7
  } state_e;

  // Synchronizers. The filtered value only follows the chain when every stage
  // agrees, so a pulse shorter than SYNC_STAGES clks never reaches the
  // protocol logic.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_f_q, sda_f_q;
  logic                   scl_dly_q, sda_dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      if (&scl_sync_q)       scl_f_q <= 1'b1;
      else if (~|scl_sync_q) scl_f_q <= 1'b0;
      if (&sda_sync_q)       sda_f_q <= 1'b1;
      else if (~|sda_sync_q) sda_f_q <= 1'b0;
      scl_dly_q  <= scl_f_q;
      sda_dly_q  <= sda_f_q;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_f_q & ~scl_dly_q;
  assign scl_fall = ~scl_f_q & scl_dly_q;
  assign start_ev = scl_f_q & scl_dly_q & sda_dly_q & ~sda_f_q;
  assign stop_ev  = scl_f_q & scl_dly_q & ~sda_dly_q & sda_f_q;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       drive_q, drive_d;     // 1 = pull sda low
  logic       ack_ph_q, ack_ph_d;   // 1 = ACK already being driven
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rx_sh_q    <= 8'h00;
      tx_sh_q    <= 8'h00;
      rx_byte_q  <= 8'h00;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      drive_q    <= 1'b0;
      ack_ph_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      rx_byte_q  <= rx_byte_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      drive_q    <= drive_d;
      ack_ph_q   <= ack_ph_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
    end
  end

  logic [7:0] rx_sample;
  logic [3:0] cnt_inc;
  assign rx_sample = {rx_sh_q[6:0], sda_f_q};
  assign cnt_inc   = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    rx_byte_d  = rx_byte_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    drive_d    = drive_q;
    ack_ph_d   = ack_ph_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;

    // STOP wins over a simultaneous START.
    if (stop_ev) begin
      state_d = ST_IDLE;
      drive_d = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 4'd0;
    end else if (start_ev) begin
      state_d = ST_ADDR;
      drive_d = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          rx_sh_d = rx_sample;
          cnt_d   = cnt_inc;
          if (cnt_q == 4'd7) begin
            if (rx_sample[7:1] == TARGET_ADDR) begin
              rw_d     = rx_sample[0];
              busy_d   = 1'b1;
              ack_ph_d = 1'b0;
              state_d  = ST_ACK_ADDR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ACK_ADDR, ST_ACK_RX: if (scl_fall) begin
          if (!ack_ph_q) begin
            drive_d  = 1'b1;
            ack_ph_d = 1'b1;
          end else begin
            drive_d  = 1'b0;
            ack_ph_d = 1'b0;
            cnt_d    = 4'd0;
            if (state_q == ST_ACK_ADDR && rw_q) begin
              // Read: the MSB goes out on this same falling edge.
              state_d   = ST_TX_BYTE;
              tx_load_d = 1'b1;
              drive_d   = ~tx_byte[7];
              tx_sh_d   = {tx_byte[6:0], 1'b0};
              cnt_d     = 4'd1;
            end else begin
              state_d = ST_RX_BYTE;
            end
          end
        end
        ST_RX_BYTE: if (scl_rise) begin
          rx_sh_d = rx_sample;
          cnt_d   = cnt_inc;
          if (cnt_q == 4'd7) begin
            rx_byte_d  = rx_sample;
            rx_valid_d = 1'b1;
            ack_ph_d   = 1'b0;
            state_d    = ST_ACK_RX;
          end
        end
        // cnt_q holds the number of bits already presented.
        ST_TX_BYTE: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            drive_d = 1'b0;
            cnt_d   = 4'd0;
            state_d = ST_WAIT_ACK;
          end else begin
            drive_d = ~tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            cnt_d   = cnt_inc;
          end
        end
        // Entered on scl_rise here, so the MSB waits for the following
        // scl_fall (cnt=0) to keep sda stable while scl is high.
        ST_WAIT_ACK: if (scl_rise) begin
          if (!sda_f_q) begin
            tx_load_d = 1'b1;
            tx_sh_d   = tx_byte;
            cnt_d     = 4'd0;
            state_d   = ST_TX_BYTE;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IGNORE;
          end
        end
        default: ;  // IDLE and IGNORE wait for START/STOP
      endcase
    end
  end

  assign sda      = drive_q ? 1'b0 : 1'bz;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule
